// File: rtl/cdb_arbiter_if.sv
// Purpose : execution-unit -> CDB result handshake plus the registered CDB broadcast.
// Latency : n/a (signal bundle only).
// Backpr. : src_rdy is the per-unit accept; the broadcast side never stalls.
//
// Signals:
//   src_req   [NUM_SRC]        per-unit result valid, held until accepted
//   src_tag   [NUM_SRC*TAG_W]  per-unit tag, unit i at [i*TAG_W +: TAG_W]
//   src_wdata [NUM_SRC*DATA_W] per-unit result, unit i at [i*DATA_W +: DATA_W]
//   src_rdy   [NUM_SRC]        per-unit grant (one-hot or zero)
//   cdb_vld/cdb_tag/cdb_wdata/cdb_src  registered broadcast
// Modports: master = execution-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
);
   localparam int SRC_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]        src_req;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic [NUM_SRC*DATA_W-1:0] src_wdata;
   logic [NUM_SRC-1:0]        src_rdy;
   logic                      cdb_vld;
   logic [TAG_W-1:0]          cdb_tag;
   logic [DATA_W-1:0]         cdb_wdata;
   logic [SRC_W-1:0]          cdb_src;

   modport master (
      output src_req, src_tag, src_wdata,
      input  src_rdy, cdb_vld, cdb_tag, cdb_wdata, cdb_src
   );

   modport slave (
      input  src_req, src_tag, src_wdata,
      output src_rdy, cdb_vld, cdb_tag, cdb_wdata, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose : round-robin arbiter picking one completed execution-unit result per cycle for the CDB.
// Latency : result accepted in cycle N is broadcast in cycle N+1 (exactly one cycle).
// Backpr. : per-unit src_rdy grant, zero during flush; the CDB itself never stalls.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-low reset
//   i_flush      synchronous pipeline flush (blocks grants, does not move the pointer)
//   bus          cdb_arbiter_if.slave: src_req/src_tag/src_wdata in, src_rdy and cdb_* out
//   o_bcast_cnt  broadcasts since reset, wraps, unaffected by flush
// NUM_SRC is expected in 2..8.
module cdb_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   cdb_arbiter_if.slave        bus,
   output logic [31:0]         o_bcast_cnt
);
   localparam int SRC_W = $clog2(NUM_SRC);

   // Scan index is one bit wider than the pointer so ptr+k cannot overflow before the wrap.
   localparam logic [SRC_W:0]   NUM_SRC_EXT = (SRC_W+1)'(NUM_SRC);
   localparam logic [SRC_W-1:0] LAST_IDX    = SRC_W'(NUM_SRC - 1);

   // ---------------- state ----------------
   logic [SRC_W-1:0]  r_ptr;
   logic              r_cdb_vld;
   logic [TAG_W-1:0]  r_cdb_tag;
   logic [DATA_W-1:0] r_cdb_wdata;
   logic [SRC_W-1:0]  r_cdb_src;
   logic [31:0]       r_bcast_cnt;

   // ---------------- combinational ----------------
   logic [TAG_W-1:0]  w_tag   [NUM_SRC];
   logic [DATA_W-1:0] w_wdata [NUM_SRC];
   logic [SRC_W:0]    w_scan;
   logic              w_found;
   logic [SRC_W-1:0]  w_gnt_idx;
   logic              w_gnt_vld;
   logic [NUM_SRC-1:0] w_rdy;
   logic [SRC_W-1:0]  w_ptr_nxt;

   // Unpack the flat per-unit buses.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         w_tag[i]   = bus.src_tag[i*TAG_W +: TAG_W];
         w_wdata[i] = bus.src_wdata[i*DATA_W +: DATA_W];
      end
   end

   // Round-robin scan: start at r_ptr, ascend, wrap explicitly at NUM_SRC so a
   // non-power-of-two unit count never decodes a nonexistent unit.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_scan    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_scan = {1'b0, r_ptr} + (SRC_W+1)'(k);
         if (w_scan >= NUM_SRC_EXT) begin
            w_scan = w_scan - NUM_SRC_EXT;
         end
         if (!w_found && bus.src_req[w_scan[SRC_W-1:0]]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_scan[SRC_W-1:0];
         end
      end
   end

   // Flush suppresses the grant; a winner is only ever a requesting unit, so
   // src_rdy can never assert on an idle unit and grant implies transfer.
   assign w_gnt_vld = w_found & ~i_flush;

   always_comb begin
      w_rdy = '0;
      if (w_gnt_vld) begin
         w_rdy[w_gnt_idx] = 1'b1;
      end
   end

   assign w_ptr_nxt = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + SRC_W'(1);

   // ---------------- registers ----------------
   // Pointer and counter move only on a transfer; a cycle without one drops
   // the broadcast and clears its payload, but keeps the last producer index.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_ptr       <= '0;
         r_cdb_vld   <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_wdata <= '0;
         r_cdb_src   <= '0;
         r_bcast_cnt <= '0;
      end else if (w_gnt_vld) begin
         r_ptr       <= w_ptr_nxt;
         r_cdb_vld   <= 1'b1;
         r_cdb_tag   <= w_tag[w_gnt_idx];
         r_cdb_wdata <= w_wdata[w_gnt_idx];
         r_cdb_src   <= w_gnt_idx;
         r_bcast_cnt <= r_bcast_cnt + 32'd1;
      end else begin
         r_cdb_vld   <= 1'b0;
         r_cdb_tag   <= '0;
         r_cdb_wdata <= '0;
      end
   end

   // ---------------- outputs ----------------
   assign bus.src_rdy   = w_rdy;
   assign bus.cdb_vld   = r_cdb_vld;
   assign bus.cdb_tag   = r_cdb_tag;
   assign bus.cdb_wdata = r_cdb_wdata;
   assign bus.cdb_src   = r_cdb_src;
   assign o_bcast_cnt   = r_bcast_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : self-checking bench for cdb_arbiter against a round-robin reference model.
// Latency : model expects the broadcast one cycle after each grant.
// Backpr. : units hold req/tag/wdata until granted, as the handshake requires.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int TW = 4;
   localparam int DW = 32;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] bcast_cnt;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_flush     (flush),
      .bus         (bus),
      .o_bcast_cnt (bcast_cnt)
   );

   // stimulus state (one entry per execution unit)
   logic [N-1:0]  req;
   logic [TW-1:0] tag [N];
   logic [DW-1:0] wd  [N];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   int            m_ptr;
   bit            m_vld;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_wd;
   int            m_src;
   logic [31:0]   m_cnt;
   int            wait_cyc [N];
   int            last_g;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_vld = 0; m_tag = '0; m_wd = '0; m_src = 0; m_cnt = '0;
      for (int i = 0; i < N; i++) wait_cyc[i] = 0;
      last_g = -1;
   endtask

   // Round-robin rule: first requester at or after ptr, wrapping; none under flush.
   function automatic int exp_grant();
      if (flush) return -1;
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      bus.src_req = req;
      for (int i = 0; i < N; i++) begin
         bus.src_tag[i*TW +: TW]   = tag[i];
         bus.src_wdata[i*DW +: DW] = wd[i];
      end
   endtask

   // Called at a falling edge with req/tag/wd/flush set; returns at the next falling edge.
   task automatic step();
      int g;
      logic [N-1:0] exp_rdy;
      drive();
      #1;
      g = exp_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("src_rdy", 64'(bus.src_rdy), 64'(exp_rdy));
      for (int i = 0; i < N; i++) begin
         if (flush || !req[i] || i == g) begin
            wait_cyc[i] = 0;
         end else begin
            wait_cyc[i]++;
            chk("fair_wait", 64'(wait_cyc[i] < N), 64'(1));
         end
      end
      @(posedge clk);
      if (g >= 0) begin
         m_vld = 1'b1; m_tag = tag[g]; m_wd = wd[g]; m_src = g;
         m_ptr = (g + 1) % N; m_cnt = m_cnt + 32'd1;
      end else begin
         m_vld = 1'b0; m_tag = '0; m_wd = '0;
      end
      last_g = g;
      @(negedge clk);
      chk("cdb_vld",   64'(bus.cdb_vld),   64'(m_vld));
      chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
      chk("cdb_wdata", 64'(bus.cdb_wdata), 64'(m_wd));
      chk("cdb_src",   64'(bus.cdb_src),   64'(m_src));
      chk("bcast_cnt", 64'(bcast_cnt),     64'(m_cnt));
   endtask

   task automatic set_unit(int i);
      req[i] = 1'b1;
      tag[i] = TW'($urandom);
      wd[i]  = $urandom;
   endtask

   initial begin
      req = '0;
      for (int i = 0; i < N; i++) begin tag[i] = '0; wd[i] = '0; end
      drive();
      model_reset();

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_vld",   64'(bus.cdb_vld),   64'(0));
      chk("rst_tag",   64'(bus.cdb_tag),   64'(0));
      chk("rst_wdata", 64'(bus.cdb_wdata), 64'(0));
      chk("rst_src",   64'(bus.cdb_src),   64'(0));
      chk("rst_cnt",   64'(bcast_cnt),     64'(0));
      chk("rst_rdy",   64'(bus.src_rdy),   64'(0));
      rst_n = 1'b1;

      // contention from ptr=0: grants 0,1,2,3,0 with each unit re-requesting
      for (int i = 0; i < N; i++) set_unit(i);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("cont_src", 64'(bus.cdb_src), 64'(k % N));
         if (last_g >= 0) set_unit(last_g);
      end
      req = '0;

      // single unit: tag 3, data 0xAA
      req[0] = 1'b1; tag[0] = 4'h3; wd[0] = 32'h0000_00AA;
      step();
      chk("single_tag",   64'(bus.cdb_tag),   64'(4'h3));
      chk("single_wdata", 64'(bus.cdb_wdata), 64'(32'hAA));
      req = '0;

      // wrap/skip: move ptr to 3 via unit 2, then units 1 and 3 -> 3 then 1
      set_unit(2); step(); req = '0;
      set_unit(1); set_unit(3);
      step(); chk("skip_first", 64'(bus.cdb_src), 64'(3)); req[3] = 1'b0;
      step(); chk("skip_second", 64'(bus.cdb_src), 64'(1)); req = '0;
      for (int i = 0; i < N; i++) set_unit(i);
      step(); chk("ptr_after_wrap", 64'(bus.cdb_src), 64'(2));
      req = '0;

      // idle
      repeat (10) step();

      // flush: a registered broadcast finishes, unit 2 waits out the flush
      set_unit(0); step(); req = '0;
      flush = 1'b1; set_unit(2);
      step();
      flush = 1'b0;
      step();
      chk("flush_regrant", 64'(bus.cdb_src), 64'(2));
      req = '0;

      // async reset while a broadcast is valid
      set_unit(1); step(); set_unit(1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld",   64'(bus.cdb_vld),   64'(0));
      chk("arst_tag",   64'(bus.cdb_tag),   64'(0));
      chk("arst_wdata", 64'(bus.cdb_wdata), 64'(0));
      chk("arst_cnt",   64'(bcast_cnt),     64'(0));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_unit(3);
      step();
      chk("arst_regrant", 64'(bus.cdb_src), 64'(1));
      req = '0;

      // counter wrap
      force dut.r_bcast_cnt = 32'hFFFF_FFFF;
      #1 release dut.r_bcast_cnt;
      m_cnt = 32'hFFFF_FFFF;
      chk("cnt_preset", 64'(bcast_cnt), 64'(32'hFFFF_FFFF));
      set_unit(0); step();
      chk("cnt_wrap", 64'(bcast_cnt), 64'(0));
      req = '0;

      // randomized traffic with occasional flush
      for (int c = 0; c < 400; c++) begin
         if (last_g >= 0) req[last_g] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) set_unit(i);
         end
         flush = ($urandom_range(0, 15) == 0);
         step();
      end
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
